// File: rtl/matrix_uart_host_if.sv
// Host-side bundle of the matrix UART initiator: operand load, start/status,
// serial pins and the result read port.
interface matrix_uart_host_if;
  logic       load_we;
  logic [4:0] load_addr;
  logic [7:0] load_data;
  logic       start;
  logic       tx;
  logic       rx;
  logic [3:0] res_addr;
  logic [7:0] res_data;
  logic [3:0] rx_count;
  logic       busy;
  logic       done;
  logic       err_frame;
  logic       err_timeout;

  modport master (
    output load_we, load_addr, load_data, start, rx, res_addr,
    input  tx, res_data, rx_count, busy, done, err_frame, err_timeout
  );

  modport slave (
    input  load_we, load_addr, load_data, start, rx, res_addr,
    output tx, res_data, rx_count, busy, done, err_frame, err_timeout
  );
endinterface

// File: rtl/matrix_uart_host.sv
// Sends an 18-byte operand buffer (A then B) as 8N1 frames, then collects the
// 9 result bytes from the multiplier; results readable with one cycle latency.
module matrix_uart_host #(
  parameter int CLOCK_RATE     = 100000000,
  parameter int BAUD_RATE      = 9600,
  parameter int GAP_CYCLES     = 12500,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input logic               clk,
  input logic               rst_n,
  matrix_uart_host_if.slave bus
);

  localparam int          CLKS_PER_BIT = CLOCK_RATE / BAUD_RATE;
  localparam logic [31:0] BIT_M1       = 32'(CLKS_PER_BIT - 1);
  localparam logic [31:0] HALF_M1      = 32'(CLKS_PER_BIT / 2 - 1);
  localparam logic [31:0] GAP_M1       = 32'(GAP_CYCLES - 1);
  localparam logic [31:0] TO_M1        = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, SEND, GAP, RECV, FINISH} state_t;

  state_t      state;
  logic [7:0]  op_buf  [18];
  logic [7:0]  res_buf [9];
  logic [4:0]  byte_idx;
  logic [3:0]  bit_idx;
  logic [31:0] cnt;
  logic        tx_q, busy_q, done_q, err_frame_q, err_timeout_q;
  logic [3:0]  rx_count_q;
  logic [7:0]  res_data_q;

  logic        rx_s1, rx_s2, rx_prev;
  logic        r_act;
  logic [3:0]  r_bit;
  logic [31:0] r_cnt;
  logic [7:0]  r_shift;
  logic [31:0] idle_cnt;

  assign bus.tx          = tx_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.err_frame   = err_frame_q;
  assign bus.err_timeout = err_timeout_q;
  assign bus.rx_count    = rx_count_q;
  assign bus.res_data    = res_data_q;

  // rx_prev trails the synchronised line by one cycle for falling-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= bus.rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      for (int i = 0; i < 18; i++) op_buf[i] <= 8'd0;
      for (int i = 0; i < 9; i++) res_buf[i] <= 8'd0;
      byte_idx      <= 5'd0;
      bit_idx       <= 4'd0;
      cnt           <= 32'd0;
      tx_q          <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_frame_q   <= 1'b0;
      err_timeout_q <= 1'b0;
      rx_count_q    <= 4'd0;
      res_data_q    <= 8'd0;
      r_act         <= 1'b0;
      r_bit         <= 4'd0;
      r_cnt         <= 32'd0;
      r_shift       <= 8'd0;
      idle_cnt      <= 32'd0;
    end else begin
      done_q     <= 1'b0;
      res_data_q <= (bus.res_addr < 4'd9) ? res_buf[bus.res_addr] : 8'd0;
      case (state)
        IDLE: begin
          busy_q <= 1'b0;
          if (bus.load_we && bus.load_addr < 5'd18)
            op_buf[bus.load_addr] <= bus.load_data;
          if (bus.start) begin
            state         <= SEND;
            busy_q        <= 1'b1;
            tx_q          <= 1'b0;
            byte_idx      <= 5'd0;
            bit_idx       <= 4'd0;
            cnt           <= 32'd0;
            err_frame_q   <= 1'b0;
            err_timeout_q <= 1'b0;
            rx_count_q    <= 4'd0;
            for (int i = 0; i < 9; i++) res_buf[i] <= 8'd0;
          end
        end
        SEND: begin
          if (cnt == BIT_M1) begin
            cnt <= 32'd0;
            if (bit_idx == 4'd9) begin
              if (byte_idx == 5'd17) begin
                state    <= RECV;
                r_act    <= 1'b0;
                idle_cnt <= 32'd0;
              end else begin
                state <= GAP;
              end
            end else begin
              // bit_idx 0 is the start bit, 1..8 carry data bits 0..7
              bit_idx <= bit_idx + 4'd1;
              tx_q    <= (bit_idx == 4'd8) ? 1'b1 : op_buf[byte_idx][bit_idx[2:0]];
            end
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        GAP: begin
          if (cnt == GAP_M1) begin
            cnt      <= 32'd0;
            byte_idx <= byte_idx + 5'd1;
            bit_idx  <= 4'd0;
            tx_q     <= 1'b0;
            state    <= SEND;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        RECV: begin
          if (idle_cnt == TO_M1) begin
            err_timeout_q <= 1'b1;
            state         <= FINISH;
          end else begin
            idle_cnt <= idle_cnt + 32'd1;
          end
          if (!r_act) begin
            if (rx_prev && !rx_s2) begin
              r_act <= 1'b1;
              r_cnt <= 32'd0;
              r_bit <= 4'd0;
            end
          end else if ((r_bit == 4'd0 && r_cnt == HALF_M1) ||
                       (r_bit != 4'd0 && r_cnt == BIT_M1)) begin
            r_cnt <= 32'd0;
            if (r_bit == 4'd0) begin
              // a start bit that is high again at mid-bit was only a glitch
              if (rx_s2) begin
                r_act <= 1'b0;
              end else begin
                r_bit    <= 4'd1;
                idle_cnt <= 32'd0;
              end
            end else if (r_bit < 4'd9) begin
              r_shift <= {rx_s2, r_shift[7:1]};
              r_bit   <= r_bit + 4'd1;
            end else begin
              r_act <= 1'b0;
              if (rx_s2) begin
                res_buf[rx_count_q] <= r_shift;
                rx_count_q          <= rx_count_q + 4'd1;
                if (rx_count_q == 4'd8) state <= FINISH;
              end else begin
                err_frame_q <= 1'b1;
              end
            end
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        FINISH: begin
          done_q <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_uart_host.sv
// Randomised and directed transactions against a behavioural model of the
// operand frames, the matrix product and the result buffer.
module tb_matrix_uart_host;

  localparam int CPB  = 8;
  localparam int GAPC = 20;
  localparam int TMO  = 3000;
  localparam int FP   = 10 * CPB + GAPC;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  matrix_uart_host_if bus ();

  matrix_uart_host #(
    .CLOCK_RATE(800), .BAUD_RATE(100), .GAP_CYCLES(GAPC), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int done_cnt = 0;
  int last_done_cyc = 0;
  logic done_busy = 1'b0;
  logic [7:0] op_m [18];
  logic [7:0] exp_res [9];
  bit chk_en = 0;
  logic [3:0] man_addr = 4'd0;
  logic [3:0] prev_addr = 4'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.done) begin
      done_cnt      <= done_cnt + 1;
      last_done_cyc <= cyc;
      done_busy     <= bus.busy;
    end
  end

  // idle-time compare: random result reads against the model, line idle
  always @(negedge clk) begin
    if (chk_en) begin
      check("res_data", 32'(bus.res_data), (prev_addr < 4'd9) ? 32'(exp_res[prev_addr]) : 32'd0);
      check("idle_out", 32'({bus.tx, bus.busy, bus.done}), 32'(3'b100));
      prev_addr    = 4'($urandom_range(0, 15));
      bus.res_addr = prev_addr;
    end else begin
      bus.res_addr = man_addr;
      prev_addr    = man_addr;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic load(input int a, input logic [7:0] d);
    bus.load_we   = 1'b1;
    bus.load_addr = 5'(a);
    bus.load_data = d;
    tick();
    bus.load_we = 1'b0;
    if (a < 18) op_m[a] = d;
  endtask

  function automatic logic [7:0] prod(input int i);
    int s;
    s = 0;
    for (int k = 0; k < 3; k++)
      s += int'(op_m[(i / 3) * 3 + k]) * int'(op_m[9 + k * 3 + i % 3]);
    return 8'(s);
  endfunction

  task automatic send_frame(input logic [7:0] b, input logic stop);
    bus.rx = 1'b1;
    repeat (2 * CPB) tick();
    bus.rx = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      repeat (CPB) tick();
    end
    bus.rx = stop;
    repeat (CPB) tick();
    bus.rx = 1'b1;
  endtask

  task automatic read_res(input int a, input logic [7:0] e);
    chk_en   = 0;
    man_addr = 4'(a);
    repeat (3) tick();
    check($sformatf("res_lit%0d", a), 32'(bus.res_data), 32'(e));
  endtask

  // mode 0: responder returns the product (frame 'bad' gets a low stop bit); mode 1: silent line
  task automatic run_txn(input int mode, input int bad, input bit glitch, input bit mess,
                         input int sim_a, input logic [7:0] sim_d);
    int r_cyc, d0, got, lat;
    bit ok;
    logic exp_tx;
    logic [7:0] resp [9];
    chk_en = 0;
    d0 = done_cnt;
    bus.start = 1'b1;
    if (sim_a >= 0) begin
      bus.load_we = 1'b1; bus.load_addr = 5'(sim_a); bus.load_data = sim_d;
      op_m[sim_a] = sim_d;
    end
    tick();
    bus.start = 1'b0; bus.load_we = 1'b0;
    check("start_busy", 32'(bus.busy), 32'd1);
    check("start_clr", 32'({bus.err_frame, bus.err_timeout, bus.rx_count}), 32'd0);
    for (int k = 0; k < 18; k++) begin
      ok = 1;
      for (int off = 0; off < FP && !(k == 17 && off >= 10 * CPB); off++) begin
        if (off >= 9 * CPB) exp_tx = 1'b1;
        else if (off < CPB) exp_tx = 1'b0;
        else exp_tx = op_m[k][off / CPB - 1];
        if (bus.tx !== exp_tx) ok = 0;
        if (mess && k == 2 && off == 0) begin
          bus.start = 1'b1; bus.load_we = 1'b1; bus.load_addr = 5'd17; bus.load_data = 8'hAA;
        end else if (mess && k == 2 && off == 1) begin
          bus.start = 1'b0; bus.load_we = 1'b0;
        end
        tick();
      end
      check($sformatf("tx_frame%0d", k), 32'(ok), 32'd1);
    end
    check("recv_busy", 32'(bus.busy), 32'd1);
    r_cyc = cyc;
    for (int j = 0; j < 9; j++) resp[j] = prod(j);
    if (glitch) begin
      repeat (30) tick();
      bus.rx = 1'b0;
      repeat (2) tick();
      bus.rx = 1'b1;
      repeat (60) tick();
      check("glitch_ignored", 32'({bus.err_frame, bus.rx_count}), 32'd0);
    end
    if (mode == 0)
      for (int j = 0; j < 9; j++) send_frame(resp[j], (j != bad));
    for (int w = 0; w < TMO + 500 && done_cnt == d0; w++) tick();
    check("done_seen", 32'(done_cnt != d0), 32'd1);
    check("done_with_busy", 32'(done_busy), 32'd1);
    check("after_done", 32'({bus.busy, bus.done}), 32'd0);
    if (mode == 1) begin
      lat = last_done_cyc - r_cyc;
      check("timeout_lat", 32'(lat >= TMO - 1 && lat <= TMO + 3), 32'd1);
    end
    got = 0;
    for (int j = 0; j < 9; j++) begin
      if (mode == 0 && j != bad) begin
        exp_res[got] = resp[j];
        got++;
      end
    end
    for (int j = got; j < 9; j++) exp_res[j] = 8'd0;
    check("rx_count", 32'(bus.rx_count), 32'(got));
    check("err_frame", 32'(bus.err_frame), 32'(mode == 0 && bad >= 0 && bad < 9));
    check("err_timeout", 32'(bus.err_timeout), 32'(got < 9));
    repeat (2) tick();
    check("done_once", 32'(done_cnt - d0), 32'd1);
    chk_en = 1;
    repeat (40) tick();
  endtask

  initial begin
    bus.load_we = 1'b0; bus.load_addr = 5'd0; bus.load_data = 8'd0;
    bus.start = 1'b0; bus.rx = 1'b1;
    for (int i = 0; i < 18; i++) op_m[i] = 8'd0;
    for (int i = 0; i < 9; i++) exp_res[i] = 8'd0;
    repeat (3) tick();
    check("rst_out", 32'({bus.tx, bus.busy, bus.done, bus.err_frame, bus.err_timeout}), 32'(5'b10000));
    check("rst_cnt_res", 32'({bus.rx_count, bus.res_data}), 32'd0);
    rst_n = 1'b1;
    chk_en = 1;
    repeat (10) tick();

    // identity times 1..9, last operand written in the start cycle
    for (int i = 0; i < 9; i++) load(i, (i % 4 == 0) ? 8'd1 : 8'd0);
    for (int i = 0; i < 8; i++) load(9 + i, 8'(i + 1));
    run_txn(0, -1, 0, 0, 17, 8'd9);
    for (int i = 0; i < 9; i++) check($sformatf("model_id%0d", i), 32'(exp_res[i]), 32'(i + 1));
    read_res(4, 8'd5);
    read_res(8, 8'd9);
    read_res(12, 8'd0);
    chk_en = 1;

    for (int i = 0; i < 18; i++) load(i, (i < 9) ? 8'd2 : 8'd3);
    run_txn(0, -1, 0, 0, -1, 8'd0);
    read_res(0, 8'd18);
    read_res(7, 8'd18);
    chk_en = 1;

    for (int i = 0; i < 18; i++) load(i, 8'd255);
    run_txn(0, -1, 0, 0, -1, 8'd0);
    read_res(3, 8'd3);
    chk_en = 1;

    // random operands plus stray writes to unused addresses
    for (int i = 0; i < 24; i++) load($urandom_range(0, 31), 8'($urandom));
    for (int i = 0; i < 18; i++) load(i, 8'($urandom));
    for (int i = 0; i < 4; i++) load($urandom_range(18, 31), 8'($urandom));
    run_txn(0, -1, 0, 0, -1, 8'd0);

    run_txn(0, 4, 0, 0, -1, 8'd0);
    check("frame_cnt_lit", 32'(bus.rx_count), 32'd8);

    run_txn(1, -1, 1, 0, -1, 8'd0);
    check("silent_cnt_lit", 32'(bus.rx_count), 32'd0);

    // asynchronous reset in the middle of SEND
    chk_en = 0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (150) tick();
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out", 32'({bus.tx, bus.busy, bus.done}), 32'(3'b100));
    check("midrst_res", 32'({bus.rx_count, bus.res_data}), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 18; i++) op_m[i] = 8'd0;
    for (int i = 0; i < 9; i++) exp_res[i] = 8'd0;
    chk_en = 1;
    repeat (10) tick();

    // start and load_we pulsed while busy must leave the zeroed operands untouched
    run_txn(1, -1, 0, 1, -1, 8'd0);

    chk_en = 0;
    tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
